// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-decode helpers for the load/store unit.
// LSU_MISALIGN_EN (see lsu.sv) enables the split-access states RD2_DATA and WR2.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        RD2_DATA,
        WR,
        WR2,
        RESP
    } state_t;

    // A zero mask marks an undefined funct3.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_mask = MASK_B;
            F3_H, F3_HU: size_mask = MASK_H;
            F3_W:        size_mask = MASK_W;
            default:     size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        return (size_mask(f3) == 4'b0000) || (we && f3[2]);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (size_mask(f3) == MASK_H && off[0]) || (size_mask(f3) == MASK_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: store shift and strobes, load extract and extend,
// both over a 64-bit two-word window so word-crossing accesses use the same path.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [63:0] rwin,
    output logic [7:0]  mask,
    output logic [63:0] wwin,
    output logic [31:0] rdata
);
    logic [31:0] lane;
    logic [31:0] unused_top;

    assign mask = {4'b0000, size_mask(funct3)} << off;
    assign wwin = {32'b0, wdata} << {off, 3'b000};
    assign {unused_top, lane} = rwin >> {off, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    rdata = {{24{lane[7]}}, lane[7:0]};
            F3_H:    rdata = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   rdata = {24'b0, lane[7:0]};
            F3_HU:   rdata = {16'b0, lane[15:0]};
            default: rdata = lane;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one RV32I load or store at a time onto the word-addressed data RAM.
// Define LSU_MISALIGN_EN to split word-crossing accesses instead of rejecting misaligned ones.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [29:0] mem_r_addr,
    input  logic [31:0] mem_r_val,
    output logic        mem_w_enable,
    output logic [29:0] mem_w_addr,
    output logic [31:0] mem_w_val,
    output logic [3:0]  mem_byte_en
);
    state_t      state, state_nx;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  f3_q;
    logic [7:0]  mask;
    logic [63:0] wwin, rwin;
    logic [31:0] ld_data;
    logic [29:0] wa;
    logic        accept, bad;

    assign wa        = addr_q[31:2];
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_EN
    logic [31:0] word0;
    logic [29:0] wa_nx;
    logic        cross;

    assign wa_nx = wa + 30'd1;
    assign cross = |mask[7:4];
    assign bad   = is_illegal(req_we, req_funct3);
    assign rwin  = (state == RD2_DATA) ? {mem_r_val, word0} : {32'b0, mem_r_val};

    always_ff @(posedge clk) begin
        if (rst)                    word0 <= '0;
        else if (state == RD_DATA)  word0 <= mem_r_val;
    end
`else
    logic unused_hi;

    assign bad       = is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
    assign rwin      = {32'b0, mem_r_val};
    assign unused_hi = ^{mask[7:4], wwin[63:32]};
`endif

    lsu_align u_align (
        .funct3(f3_q),
        .off   (addr_q[1:0]),
        .wdata (wdata_q),
        .rwin  (rwin),
        .mask  (mask),
        .wwin  (wwin),
        .rdata (ld_data)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = bad ? RESP : (req_we ? WR : RD_ADDR);
            RD_ADDR:  state_nx = RD_DATA;
`ifdef LSU_MISALIGN_EN
            RD_DATA:  state_nx = cross ? RD2_DATA : RESP;
            RD2_DATA: state_nx = RESP;
            WR:       state_nx = cross ? WR2 : RESP;
            WR2:      state_nx = RESP;
`else
            RD_DATA:  state_nx = RESP;
            WR:       state_nx = RESP;
`endif
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // The RAM writes on strobes alone, so reset must kill them combinationally.
    always_comb begin
        mem_w_enable = 1'b0;
        mem_w_addr   = '0;
        mem_w_val    = '0;
        mem_byte_en  = '0;
        mem_r_addr   = wa;
        if (!rst && state == WR) begin
            mem_w_enable = 1'b1;
            mem_w_addr   = wa;
            mem_w_val    = wwin[31:0];
            mem_byte_en  = mask[3:0];
        end
`ifdef LSU_MISALIGN_EN
        if (!rst && state == WR2) begin
            mem_w_enable = 1'b1;
            mem_w_addr   = wa_nx;
            mem_w_val    = wwin[63:32];
            mem_byte_en  = mask[7:4];
        end
        if (state == RD_DATA && cross) mem_r_addr = wa_nx;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
            // Only a rejected request goes straight from IDLE to RESP.
            resp_valid <= (state_nx == RESP);
            resp_err   <= (state == IDLE) && (state_nx == RESP);
            resp_rdata <= (state_nx == RESP && (state == RD_DATA || state == RD2_DATA)) ? ld_data : '0;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a byte-level memory model and
// per-transaction timing expectations; directed cases pin the model with literals.
module tb_lsu;
`ifdef LSU_MISALIGN_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_w_enable;
    logic [31:0] resp_rdata, mem_r_val, mem_w_val;
    logic [29:0] mem_r_addr, mem_w_addr;
    logic [3:0]  mem_byte_en;

    lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_r_addr(mem_r_addr), .mem_r_val(mem_r_val), .mem_w_enable(mem_w_enable),
        .mem_w_addr(mem_w_addr), .mem_w_val(mem_w_val), .mem_byte_en(mem_byte_en)
    );

    always #5 clk = ~clk;

    // RAM: registered read, byte-strobed write, plus a backdoor for preloading.
    logic [31:0] ram [64];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;
    always @(posedge clk) begin
        mem_r_val <= ram[mem_r_addr[5:0]];
        for (int b = 0; b < 4; b++)
            if (mem_byte_en[b]) ram[mem_w_addr[5:0]][8*b +: 8] <= mem_w_val[8*b +: 8];
        if (bd_we) ram[bd_idx] <= bd_val;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, fails = 0;
    logic [7:0] ref_mem [256];
    logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Expectations for the current transaction, in absolute cycle numbers.
    int          acc = -100, resp_at = -100, wr1_at = -100, wr2_at = -100;
    logic [31:0] e_rdata = '0, e_wv1 = '0, e_wv2 = '0;
    logic        e_err = 1'b0;
    logic [3:0]  e_be1 = '0, e_be2 = '0;
    logic [29:0] e_wa1 = '0, e_wa2 = '0;
    bit          chk_en = 1'b0;

    typedef struct { logic [29:0] wa; logic [3:0] be; logic [31:0] wv; } wr_t;
    wr_t         o_wr [$];
    int          o_resp_at = -1000;
    logic [31:0] o_rdata;
    logic        o_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_wr(input string name, input int idx, input logic [29:0] wa,
                          input logic [3:0] be, input logic [31:0] wv);
        checks++;
        if (o_wr.size() <= idx) begin
            fails++;
            $display("FAIL %s: saw %0d write cycles, expected at least %0d", name, o_wr.size(), idx + 1);
        end else begin
            chk({name, " addr"}, 32'(o_wr[idx].wa), 32'(wa));
            chk({name, " strobes"}, 32'(o_wr[idx].be), 32'(be));
            chk({name, " data"}, o_wr[idx].wv, wv);
        end
    endtask

    // Behavioural model: byte memory plus latency rules, evaluated once per accepted request.
    task automatic model_accept(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int size, off;
        bit ill, mis, crs;
        logic [63:0] v, d64;
        logic [7:0] m8;
        off  = int'(a[1:0]);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ill  = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]);
        mis  = (off % size) != 0;
        crs  = (off + size) > 4;
        acc = cyc; wr1_at = -100; wr2_at = -100; e_rdata = '0; e_err = 1'b0;
        if (ill || (mis && !EN)) begin
            e_err = 1'b1;
            resp_at = acc;
        end else if (we) begin
            m8  = 8'((1 << size) - 1) << off;
            d64 = {32'b0, d} << (8 * off);
            e_be1 = m8[3:0]; e_be2 = m8[7:4];
            e_wa1 = a[31:2]; e_wa2 = 30'(a[31:2] + 30'd1);
            e_wv1 = d64[31:0]; e_wv2 = d64[63:32];
            wr1_at = acc;
            if (crs) wr2_at = acc + 1;
            resp_at = acc + 1 + int'(crs);
            for (int i = 0; i < size; i++) ref_mem[8'(a + 32'(i))] = d[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
            if (!f3[2] && size < 4 && v[8*size-1]) v[31:0] = v[31:0] | (32'hFFFFFFFF << (8 * size));
            e_rdata = v[31:0];
            resp_at = acc + 2 + int'(crs);
        end
    endtask

    // Compare process: every cycle, outputs against the current expectations.
    always @(negedge clk) begin
        logic [3:0] xbe;
        if (chk_en && !rst) begin
            chk("req_ready", 32'(req_ready), 32'(!(cyc >= acc && cyc <= resp_at)));
            chk("resp_valid", 32'(resp_valid), 32'(cyc == resp_at));
            if (resp_valid) begin
                o_resp_at = cyc; o_rdata = resp_rdata; o_err = resp_err;
                if (cyc == resp_at) begin
                    chk("resp_rdata", resp_rdata, e_rdata);
                    chk("resp_err", 32'(resp_err), 32'(e_err));
                end
            end else begin
                chk("resp_err idle", 32'(resp_err), 32'd0);
            end
            xbe = (cyc == wr1_at) ? e_be1 : (cyc == wr2_at) ? e_be2 : 4'b0000;
            chk("mem_byte_en", 32'(mem_byte_en), 32'(xbe));
            chk("mem_w_enable", 32'(mem_w_enable), 32'(xbe != 4'b0000));
            if (xbe != 4'b0000) begin
                chk("mem_w_addr", 32'(mem_w_addr), 32'((cyc == wr1_at) ? e_wa1 : e_wa2));
                chk("mem_w_val", mem_w_val, (cyc == wr1_at) ? e_wv1 : e_wv2);
            end
            if (mem_byte_en != 4'b0000) o_wr.push_back('{mem_w_addr, mem_byte_en, mem_w_val});
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit model);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!req_ready) begin
            fails++;
            $display("FAIL ready_timeout: req_ready 0 after 20 cycles, expected 1");
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        o_wr.delete(); o_resp_at = -1000; o_rdata = 'x; o_err = 1'bx;
        if (model) model_accept(we, f3, a, d);
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        issue(we, f3, a, d, 1'b1);
        while (cyc <= resp_at) @(negedge clk);
    endtask

    task automatic set_word(input int w, input logic [31:0] v);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = 6'(w); bd_val = v;
        @(posedge clk); #1 bd_we = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[8'(4 * w + i)] = v[8*i +: 8];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < 64; w++) set_word(w, $urandom);
        @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst mem_r_addr", 32'(mem_r_addr), 32'd0);
        chk("rst mem_w_enable", 32'(mem_w_enable), 32'd0);
        chk("rst mem_w_addr", 32'(mem_w_addr), 32'd0);
        chk("rst mem_w_val", mem_w_val, 32'd0);
        chk("rst mem_byte_en", 32'(mem_byte_en), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready after rst", 32'(req_ready), 32'd1);
        chk_en = 1'b1;

        // Byte/half loads with sign and zero extension.
        set_word(4, 32'h8899AABB);
        run(1'b0, 3'b000, 32'h11, 32'h0);
        chk("LB 0x11", o_rdata, 32'hFFFFFFAA);
        chk("LB latency", 32'(o_resp_at - acc), 32'd2);
        run(1'b0, 3'b100, 32'h13, 32'h0);
        chk("LBU 0x13", o_rdata, 32'h00000088);
        run(1'b0, 3'b001, 32'h12, 32'h0);
        chk("LH 0x12", o_rdata, 32'hFFFF8899);
        chk("LH latency", 32'(o_resp_at - acc), 32'd2);

        // Byte store then word readback.
        set_word(8, 32'h11223344);
        run(1'b1, 3'b000, 32'h21, 32'h000000C3);
        chk_wr("SB 0x21", 0, 30'd8, 4'b0010, 32'h0000C300);
        chk("SB latency", 32'(o_resp_at - acc), 32'd1);
        run(1'b0, 3'b010, 32'h20, 32'h0);
        chk("LW 0x20", o_rdata, 32'h1122C344);

        // Reset during the write cycle must suppress the write.
        chk_en = 1'b0;
        issue(1'b1, 3'b010, 32'h20, 32'h12345678, 1'b0);
        rst = 1'b1; #1;
        chk("rst-in-WR byte_en", 32'(mem_byte_en), 32'd0);
        chk("rst-in-WR w_enable", 32'(mem_w_enable), 32'd0);
        chk("rst-in-WR ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-rst ready", 32'(req_ready), 32'd1);
        chk("post-rst resp_valid", 32'(resp_valid), 32'd0);
        acc = -100; resp_at = -100; wr1_at = -100; wr2_at = -100;
        chk_en = 1'b1;
        run(1'b0, 3'b010, 32'h20, 32'h0);
        chk("word 8 after aborted SW", o_rdata, 32'h1122C344);

        // Word-crossing load.
        set_word(4, 32'h8899AABB);
        set_word(5, 32'h00000077);
        run(1'b0, 3'b010, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_EN
        chk("LW 0x13 split", o_rdata, 32'h00007788);
        chk("LW 0x13 latency", 32'(o_resp_at - acc), 32'd3);
        run(1'b1, 3'b010, 32'h1E, 32'hDEADBEEF);
        chk_wr("SW 0x1E WR", 0, 30'd7, 4'b1100, 32'hBEEF0000);
        chk_wr("SW 0x1E WR2", 1, 30'd8, 4'b0011, 32'h0000DEAD);
`else
        chk("LW 0x13 err", 32'(o_err), 32'd1);
        chk("LW 0x13 latency", 32'(o_resp_at - acc), 32'd0);
        chk("LW 0x13 writes", 32'(o_wr.size()), 32'd0);
`endif

        // Illegal encodings.
        run(1'b0, 3'b011, 32'h40, 32'h0);
        chk("f3=011 load err", 32'(o_err), 32'd1);
        chk("f3=011 load rdata", o_rdata, 32'd0);
        chk("f3=011 latency", 32'(o_resp_at - acc), 32'd0);
        run(1'b1, 3'b100, 32'h40, 32'h55);
        chk("f3=100 store err", 32'(o_err), 32'd1);
        chk("f3=100 store writes", 32'(o_wr.size()), 32'd0);

        // Random mix against the model.
        for (int k = 0; k < 300; k++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
            a  = 32'($urandom_range(0, 247));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(we, f3, a, $urandom);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
